// File: rtl/ps2_cmd_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : ps2_cmd_scheduler_if
// Purpose  : Byte-level link between the command scheduler and the PS/2 host
//            transceiver (transmit strobe/data, busy, receive strobe/data).
// Revision : 1.0 - initial release
// ============================================================================
interface ps2_cmd_scheduler_if;
  logic       write;
  logic [7:0] tx_data;
  logic       busy;
  logic       read;
  logic [7:0] rx_data;

  modport master (
    output write,
    output tx_data,
    input  busy,
    input  read,
    input  rx_data
  );

  modport slave (
    input  write,
    input  tx_data,
    output busy,
    output read,
    output rx_data
  );
endinterface
`default_nettype wire

// File: rtl/ps2_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ps2_cmd_scheduler
// Purpose  : Round-robin scheduler for two PS/2 command sources with ACK wait,
//            resend/timeout retry and forwarding of non-ACK receive bytes.
//            Optional macro PS2_SCHED_INIT_EN: issue 0xF4 internally after
//            reset and after a 0xAA self-test report.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_cmd_scheduler #(
  parameter int ACK_TIMEOUT = 502500,
  parameter int MAX_RETRY   = 3
) (
  input  wire         clk,
  input  wire         rst_n,
  input  wire  [1:0]  i_req,
  input  wire  [15:0] i_req_cmd,
  input  wire  [15:0] i_req_param,
  input  wire  [1:0]  i_req_has_param,
  output logic [1:0]  o_grant,
  output logic        o_done,
  output logic        o_done_err,
  output logic        o_done_id,
  output logic        o_ready,
  output logic        o_rx_valid,
  output logic [7:0]  o_rx_data,
  ps2_cmd_scheduler_if.master m_ps2
);

  localparam int       c_TW       = $clog2(ACK_TIMEOUT) + 1;
  localparam int       c_RW       = $clog2(MAX_RETRY + 1);
  localparam bit [7:0] c_ACK      = 8'hFA;
  localparam bit [7:0] c_RESEND   = 8'hFE;
`ifdef PS2_SCHED_INIT_EN
  localparam bit [7:0] c_ENABLE   = 8'hF4;
  localparam bit [7:0] c_BAT_OK   = 8'hAA;
`endif

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_COMPLETE = 2'd3
  } state_t;

  state_t            r_state,         w_state_nxt;
  logic              r_phase,         w_phase_nxt;
  logic              r_cur_id,        w_cur_id_nxt;
  logic [7:0]        r_cur_cmd,       w_cur_cmd_nxt;
  logic [7:0]        r_cur_param,     w_cur_param_nxt;
  logic              r_cur_has_param, w_cur_has_param_nxt;
  logic              r_rr_ptr,        w_rr_ptr_nxt;
  logic [c_RW-1:0]   r_retry,         w_retry_nxt;
  logic [c_TW-1:0]   r_timer,         w_timer_nxt;
  logic              r_internal,      w_internal_nxt;
  logic              r_ready,         w_ready_nxt;
  logic [1:0]        r_grant,         w_grant_nxt;
  logic              r_done,          w_done_nxt;
  logic              r_done_err,      w_done_err_nxt;
  logic              r_done_id,       w_done_id_nxt;
  logic              r_write,         w_write_nxt;
  logic [7:0]        r_tx_data,       w_tx_data_nxt;
  logic              r_rx_valid,      w_rx_valid_nxt;
  logic [7:0]        r_rx_data,       w_rx_data_nxt;

  logic w_winner;
  logic w_is_ack;
  logic w_is_resend;
  logic w_timeout;
  logic w_consume;
  logic w_fin;
  logic w_fin_err;

  // On a tie the pointer names the requester that was not granted last.
  assign w_winner    = (i_req == 2'b11) ? r_rr_ptr : i_req[1];
  assign w_is_ack    = m_ps2.read && (m_ps2.rx_data == c_ACK);
  assign w_is_resend = m_ps2.read && (m_ps2.rx_data == c_RESEND);
  assign w_timeout   = (r_timer == c_TW'(ACK_TIMEOUT - 1));

`ifdef PS2_SCHED_INIT_EN
  logic w_bat_ok;
  assign w_bat_ok  = m_ps2.read && (m_ps2.rx_data == c_BAT_OK) && r_ready &&
                     (r_state == ST_IDLE);
  assign w_consume = ((r_state == ST_WAIT_ACK) && (w_is_ack || w_is_resend)) ||
                     w_bat_ok;
`else
  assign w_consume = (r_state == ST_WAIT_ACK) && (w_is_ack || w_is_resend);
`endif

  always_comb begin
    w_state_nxt         = r_state;
    w_phase_nxt         = r_phase;
    w_cur_id_nxt        = r_cur_id;
    w_cur_cmd_nxt       = r_cur_cmd;
    w_cur_param_nxt     = r_cur_param;
    w_cur_has_param_nxt = r_cur_has_param;
    w_rr_ptr_nxt        = r_rr_ptr;
    w_retry_nxt         = r_retry;
    w_timer_nxt         = r_timer;
    w_internal_nxt      = r_internal;
`ifdef PS2_SCHED_INIT_EN
    w_ready_nxt         = r_ready;
`else
    w_ready_nxt         = 1'b1;
`endif
    w_grant_nxt         = 2'b00;
    w_done_nxt          = 1'b0;
    w_done_err_nxt      = 1'b0;
    w_done_id_nxt       = 1'b0;
    w_write_nxt         = 1'b0;
    w_tx_data_nxt       = r_tx_data;
    w_rx_valid_nxt      = m_ps2.read && !w_consume;
    w_rx_data_nxt       = (m_ps2.read && !w_consume) ? m_ps2.rx_data : r_rx_data;
    w_fin               = 1'b0;
    w_fin_err           = 1'b0;

    case (r_state)
      ST_IDLE: begin
`ifdef PS2_SCHED_INIT_EN
        if (!r_ready) begin
          w_cur_cmd_nxt       = c_ENABLE;
          w_cur_has_param_nxt = 1'b0;
          w_phase_nxt         = 1'b0;
          w_retry_nxt         = '0;
          w_internal_nxt      = 1'b1;
          w_state_nxt         = ST_SEND;
        end else if (w_bat_ok) begin
          w_ready_nxt = 1'b0;
        end else if (|i_req) begin
`else
        if (r_ready && |i_req) begin
`endif
          w_grant_nxt         = w_winner ? 2'b10 : 2'b01;
          w_rr_ptr_nxt        = ~w_winner;
          w_cur_id_nxt        = w_winner;
          w_cur_cmd_nxt       = w_winner ? i_req_cmd[15:8]   : i_req_cmd[7:0];
          w_cur_param_nxt     = w_winner ? i_req_param[15:8] : i_req_param[7:0];
          w_cur_has_param_nxt = i_req_has_param[w_winner];
          w_phase_nxt         = 1'b0;
          w_retry_nxt         = '0;
          w_internal_nxt      = 1'b0;
          w_state_nxt         = ST_SEND;
        end
      end

      ST_SEND: begin
        if (!m_ps2.busy) begin
          w_tx_data_nxt = r_phase ? r_cur_param : r_cur_cmd;
          w_write_nxt   = 1'b1;
          w_timer_nxt   = '0;
          w_state_nxt   = ST_WAIT_ACK;
        end
      end

      ST_WAIT_ACK: begin
        w_timer_nxt = r_timer + 1'b1;
        // An ACK wins over a timeout landing on the same cycle.
        if (w_is_ack) begin
          w_retry_nxt = '0;
          if (!r_phase && r_cur_has_param) begin
            w_phase_nxt = 1'b1;
            w_state_nxt = ST_SEND;
          end else begin
            w_fin = 1'b1;
          end
        end else if (w_is_resend || w_timeout) begin
          if (r_retry == c_RW'(MAX_RETRY)) begin
            w_fin     = 1'b1;
            w_fin_err = 1'b1;
          end else begin
            w_retry_nxt = r_retry + 1'b1;
            w_state_nxt = ST_SEND;
          end
        end
      end

      ST_COMPLETE: begin
        w_internal_nxt = 1'b0;
        w_state_nxt    = ST_IDLE;
      end

      default: w_state_nxt = ST_IDLE;
    endcase

    // done is registered on entry so it is high for the whole COMPLETE cycle.
    if (w_fin) begin
      w_state_nxt = ST_COMPLETE;
      if (r_internal) begin
        w_ready_nxt = 1'b1;
      end else begin
        w_done_nxt     = 1'b1;
        w_done_err_nxt = w_fin_err;
        w_done_id_nxt  = r_cur_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_phase         <= 1'b0;
      r_cur_id        <= 1'b0;
      r_cur_cmd       <= 8'h00;
      r_cur_param     <= 8'h00;
      r_cur_has_param <= 1'b0;
      r_rr_ptr        <= 1'b0;
      r_retry         <= '0;
      r_timer         <= '0;
      r_internal      <= 1'b0;
      r_ready         <= 1'b0;
      r_grant         <= 2'b00;
      r_done          <= 1'b0;
      r_done_err      <= 1'b0;
      r_done_id       <= 1'b0;
      r_write         <= 1'b0;
      r_tx_data       <= 8'h00;
      r_rx_valid      <= 1'b0;
      r_rx_data       <= 8'h00;
    end else begin
      r_state         <= w_state_nxt;
      r_phase         <= w_phase_nxt;
      r_cur_id        <= w_cur_id_nxt;
      r_cur_cmd       <= w_cur_cmd_nxt;
      r_cur_param     <= w_cur_param_nxt;
      r_cur_has_param <= w_cur_has_param_nxt;
      r_rr_ptr        <= w_rr_ptr_nxt;
      r_retry         <= w_retry_nxt;
      r_timer         <= w_timer_nxt;
      r_internal      <= w_internal_nxt;
      r_ready         <= w_ready_nxt;
      r_grant         <= w_grant_nxt;
      r_done          <= w_done_nxt;
      r_done_err      <= w_done_err_nxt;
      r_done_id       <= w_done_id_nxt;
      r_write         <= w_write_nxt;
      r_tx_data       <= w_tx_data_nxt;
      r_rx_valid      <= w_rx_valid_nxt;
      r_rx_data       <= w_rx_data_nxt;
    end
  end

  assign o_grant       = r_grant;
  assign o_done        = r_done;
  assign o_done_err    = r_done_err;
  assign o_done_id     = r_done_id;
  assign o_ready       = r_ready;
  assign o_rx_valid    = r_rx_valid;
  assign o_rx_data     = r_rx_data;
  assign m_ps2.write   = r_write;
  assign m_ps2.tx_data = r_tx_data;

endmodule
`default_nettype wire
